// File: rtl/ipf_pkg.sv
// Shared constants and types for the IPF LCU scheduler.
// Frame is a fixed 128x128 image walked in LCU tiles.
package ipf_pkg;

    localparam int IMG_W  = 128;
    localparam int ADDR_W = $clog2(IMG_W * IMG_W);

    localparam logic [1:0] SZ_16 = 2'd0;
    localparam logic [1:0] SZ_32 = 2'd1;
    localparam logic [1:0] SZ_64 = 2'd2;

    typedef enum logic [1:0] {
        IPF_OFF = 2'd0,
        IPF_PO  = 2'd1,
        IPF_WO  = 2'd2
    } ipf_type_e;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM,
        DONE
    } state_e;

    // Code 3 is reserved and behaves as the largest LCU.
    function automatic logic [1:0] norm_size(input logic [1:0] code);
        return (code == 2'd3) ? SZ_64 : code;
    endfunction

endpackage

// File: rtl/ipf_addr_gen.sv
// Pixel and LCU counters walking the frame in raster LCU order,
// plus the row-major image address of the current pixel.
module ipf_addr_gen
    import ipf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              step,
    input  logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [2:0]        lcu_x,
    output logic [2:0]        lcu_y,
    output logic              last_pix,
    output logic              last_lcu
);

    logic [5:0] col;
    logic [5:0] row;
    logic [5:0] pix_max;
    logic [2:0] lcu_max;
    logic [6:0] row_abs;
    logic [6:0] col_abs;

    // Absolute row/col are the LCU index concatenated with the offset.
    always_comb begin
        pix_max = 6'd63;
        lcu_max = 3'd1;
        row_abs = {lcu_y[0], row};
        col_abs = {lcu_x[0], col};
        case (size)
            SZ_16: begin
                pix_max = 6'd15;
                lcu_max = 3'd7;
                row_abs = {lcu_y, row[3:0]};
                col_abs = {lcu_x, col[3:0]};
            end
            SZ_32: begin
                pix_max = 6'd31;
                lcu_max = 3'd3;
                row_abs = {lcu_y[1:0], row[4:0]};
                col_abs = {lcu_x[1:0], col[4:0]};
            end
            default: ;
        endcase
    end

    assign addr     = {row_abs, col_abs};
    assign last_pix = (col == pix_max) && (row == pix_max);
    assign last_lcu = (lcu_x == lcu_max) && (lcu_y == lcu_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col   <= '0;
            row   <= '0;
            lcu_x <= '0;
            lcu_y <= '0;
        end else if (clr) begin
            col   <= '0;
            row   <= '0;
            lcu_x <= '0;
            lcu_y <= '0;
        end else if (step) begin
            if (col != pix_max) begin
                col <= col + 6'd1;
            end else begin
                col <= '0;
                if (row != pix_max) begin
                    row <= row + 6'd1;
                end else begin
                    row <= '0;
                    if (lcu_x != lcu_max) begin
                        lcu_x <= lcu_x + 3'd1;
                    end else begin
                        lcu_x <= '0;
                        lcu_y <= last_lcu ? 3'd0 : lcu_y + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ipf_lcu_sched.sv
// Frame scheduler: fetches per-LCU filter parameters, then streams
// that LCU's pixels from image memory into the in-loop filter.
module ipf_lcu_sched
    import ipf_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  cfg_lcu_size,
    input  logic        prm_valid,
    output logic        prm_ready,
    input  logic [1:0]  prm_type,
    input  logic [4:0]  prm_band_pos,
    input  logic        prm_wo_class,
    input  logic [15:0] prm_offset,
    output logic        img_rd,
    output logic [13:0] img_addr,
    input  logic [7:0]  img_rdata,
    input  logic        ipf_busy,
    output logic        in_en,
    output logic [7:0]  din,
    output logic [1:0]  ipf_type,
    output logic [4:0]  ipf_band_pos,
    output logic        ipf_wo_class,
    output logic [15:0] ipf_offset,
    output logic [2:0]  lcu_x,
    output logic [2:0]  lcu_y,
    output logic [1:0]  lcu_size,
    output logic        done
);

    state_e     state;
    logic       go;
    logic [2:0] cur_x;
    logic [2:0] cur_y;
    logic       last_pix;
    logic       last_lcu;

    assign go        = start && (state == IDLE || state == DONE);
    assign prm_ready = (state == FETCH);
    assign img_rd    = (state == STREAM) && !ipf_busy;
    // Read data returns one cycle after img_rd, aligned with in_en.
    assign din       = in_en ? img_rdata : 8'd0;

    ipf_addr_gen u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clr      (go),
        .step     (img_rd),
        .size     (lcu_size),
        .addr     (img_addr),
        .lcu_x    (cur_x),
        .lcu_y    (cur_y),
        .last_pix (last_pix),
        .last_lcu (last_lcu)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            in_en        <= 1'b0;
            done         <= 1'b0;
            ipf_type     <= IPF_OFF;
            ipf_band_pos <= '0;
            ipf_wo_class <= 1'b0;
            ipf_offset   <= '0;
            lcu_x        <= '0;
            lcu_y        <= '0;
            lcu_size     <= '0;
        end else begin
            in_en <= img_rd;
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= FETCH;
                        lcu_size <= norm_size(cfg_lcu_size);
                    end
                end
                FETCH: begin
                    if (prm_valid) begin
                        state        <= STREAM;
                        ipf_type     <= prm_type;
                        ipf_band_pos <= prm_band_pos;
                        ipf_wo_class <= prm_wo_class;
                        ipf_offset   <= prm_offset;
                        lcu_x        <= cur_x;
                        lcu_y        <= cur_y;
                    end
                end
                STREAM: begin
                    if (img_rd && last_pix) begin
                        state <= last_lcu ? DONE : FETCH;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    if (go) begin
                        state    <= FETCH;
                        done     <= 1'b0;
                        lcu_size <= norm_size(cfg_lcu_size);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipf_lcu_sched.sv
// Self-checking bench for ipf_lcu_sched: table of frame configurations
// plus reset-abort sequences, all against an arithmetic frame model.
module tb_ipf_lcu_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  cfg_lcu_size;
    logic        prm_valid;
    logic        prm_ready;
    logic [1:0]  prm_type;
    logic [4:0]  prm_band_pos;
    logic        prm_wo_class;
    logic [15:0] prm_offset;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_rdata;
    logic        ipf_busy;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;
    logic        done;

    always #5 clk = ~clk;

    ipf_lcu_sched dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_lcu_size (cfg_lcu_size),
        .prm_valid    (prm_valid),
        .prm_ready    (prm_ready),
        .prm_type     (prm_type),
        .prm_band_pos (prm_band_pos),
        .prm_wo_class (prm_wo_class),
        .prm_offset   (prm_offset),
        .img_rd       (img_rd),
        .img_addr     (img_addr),
        .img_rdata    (img_rdata),
        .ipf_busy     (ipf_busy),
        .in_en        (in_en),
        .din          (din),
        .ipf_type     (ipf_type),
        .ipf_band_pos (ipf_band_pos),
        .ipf_wo_class (ipf_wo_class),
        .ipf_offset   (ipf_offset),
        .lcu_x        (lcu_x),
        .lcu_y        (lcu_y),
        .lcu_size     (lcu_size),
        .done         (done)
    );

    logic [7:0] mem [16384];

    always @(posedge clk) begin
        if (img_rd) img_rdata <= mem[img_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  t;
        logic [4:0]  bp;
        logic        w;
        logic [15:0] off;
    } prm_t;

    prm_t prm_tab[64];

    // Frame model: k-th pixel of the frame in LCU-raster, pixel-raster order.
    function automatic int exp_addr(input int s, input int k);
        int n, lcu, p;
        n   = 128 / s;
        lcu = k / (s * s);
        p   = k % (s * s);
        return ((lcu / n) * s + p / s) * 128 + (lcu % n) * s + (p % s);
    endfunction

    task automatic check_zero(input string name);
        chk(name, {prm_ready, img_rd, in_en, done, din, img_addr,
                   ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
                   lcu_x, lcu_y, lcu_size}, 0);
    endtask

    task automatic run_frame(
        input  logic [1:0] code,
        input  int         busy_pct,
        input  int         vlow_pct,
        input  int         vdelay,
        input  int         hold_at,
        input  int         start_at,
        input  int         abort_at,
        output int         n_pix,
        output int         n_hs
    );
        int s, per, total, lcu, cyc, post;
        int in_cnt, rd_cnt, hs_cnt, fcyc, busy_left;
        bit held, started, finished;
        s = (code == 2'd0) ? 16 : (code == 2'd1) ? 32 : 64;
        per = s * s;
        total = 16384;
        in_cnt = 0; rd_cnt = 0; hs_cnt = 0; fcyc = 0;
        busy_left = 0; post = -1; cyc = 0;
        held = 0; started = 0; finished = 0;
        for (int i = 0; i < 64; i++) begin
            prm_tab[i].t   = 2'($urandom_range(2));
            prm_tab[i].bp  = 5'($urandom);
            prm_tab[i].w   = 1'($urandom);
            prm_tab[i].off = 16'($urandom);
        end
        @(negedge clk);
        cfg_lcu_size = code;
        start        = 1'b1;
        prm_valid    = 1'b0;
        ipf_busy     = 1'b0;
        prm_type     = prm_tab[0].t;
        prm_band_pos = prm_tab[0].bp;
        prm_wo_class = prm_tab[0].w;
        prm_offset   = prm_tab[0].off;
        while (cyc < 40000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (in_en) begin
                if (in_cnt < total) begin
                    lcu = in_cnt / per;
                    chk("din", din, mem[exp_addr(s, in_cnt)]);
                    chk("lcu_xy", {lcu_x, lcu_y},
                        {3'(lcu % (128 / s)), 3'(lcu / (128 / s))});
                    chk("params",
                        {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset},
                        {prm_tab[lcu].t, prm_tab[lcu].bp,
                         prm_tab[lcu].w, prm_tab[lcu].off});
                end
                in_cnt++;
                if (in_cnt == total) post = 0;
            end
            if (post >= 0) begin
                chk("done_edge", done, (post >= 1) ? 1 : 0);
                if (post >= 1) begin
                    finished = 1;
                    break;
                end
                post++;
            end else begin
                chk("done_early", done, 0);
            end
            if (prm_ready && fcyc > 0) chk("gap_in_en", in_en, 0);
            if (abort_at >= 0 && in_cnt >= abort_at) begin
                reset = 1'b1;
                #1;
                check_zero("abort_zero");
                @(negedge clk);
                reset = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("post_abort_in_en", in_en, 0);
                    chk("post_abort_ready", prm_ready, 0);
                end
                n_pix = in_cnt;
                n_hs  = hs_cnt;
                return;
            end
            if (busy_left > 0) begin
                ipf_busy = 1'b1;
                busy_left--;
            end else if (hold_at >= 0 && rd_cnt == hold_at && !held) begin
                ipf_busy  = 1'b1;
                busy_left = 4;
                held      = 1;
            end else begin
                ipf_busy = ($urandom_range(99) < busy_pct);
            end
            if (start_at >= 0 && rd_cnt == start_at && !started) begin
                start   = 1'b1;
                started = 1;
            end
            if (prm_ready) begin
                prm_valid = (fcyc >= vdelay) && ($urandom_range(99) >= vlow_pct);
                fcyc++;
            end else begin
                prm_valid = 1'($urandom);
                fcyc = 0;
            end
            prm_type     = prm_tab[(hs_cnt < 64) ? hs_cnt : 63].t;
            prm_band_pos = prm_tab[(hs_cnt < 64) ? hs_cnt : 63].bp;
            prm_wo_class = prm_tab[(hs_cnt < 64) ? hs_cnt : 63].w;
            prm_offset   = prm_tab[(hs_cnt < 64) ? hs_cnt : 63].off;
            #1;
            if (img_rd) begin
                if (rd_cnt < total) chk("img_addr", img_addr, exp_addr(s, rd_cnt));
                rd_cnt++;
            end
            if (prm_ready && prm_valid) hs_cnt++;
        end
        if (!finished) chk("frame_timeout", in_cnt, total);
        n_pix = in_cnt;
        n_hs  = hs_cnt;
    endtask

    typedef struct {
        logic [1:0] code;
        int         busy_pct;
        int         vlow_pct;
        int         vdelay;
        int         hold_at;
        int         start_at;
        int         exp_lcus;
        logic [1:0] exp_size;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int np, nh;
        vecs[0] = '{2'd0, 0,  0,  0,  -1,   -1,   64, 2'd0};
        vecs[1] = '{2'd1, 15, 30, 0,  -1,   -1,   16, 2'd1};
        vecs[2] = '{2'd2, 0,  0,  10, 1000, -1,   4,  2'd2};
        vecs[3] = '{2'd3, 0,  0,  0,  -1,   5000, 4,  2'd2};

        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);

        reset = 1'b1; start = 1'b0; cfg_lcu_size = 2'd0;
        prm_valid = 1'b0; prm_type = '0; prm_band_pos = '0;
        prm_wo_class = 1'b0; prm_offset = '0; ipf_busy = 1'b0;
        #1;
        check_zero("reset_state");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_zero("idle_after_reset");

        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].code, vecs[v].busy_pct, vecs[v].vlow_pct,
                      vecs[v].vdelay, vecs[v].hold_at, vecs[v].start_at,
                      -1, np, nh);
            chk("pix_total", np, 16384);
            chk("lcu_count", nh, vecs[v].exp_lcus);
            chk("lcu_size", lcu_size, vecs[v].exp_size);
            repeat (3) @(negedge clk);
            chk("done_hold", done, 1);
            chk("ready_in_done", prm_ready, 0);
        end

        // Abort during the 3rd 32x32 LCU, then restart and abort early.
        run_frame(2'd1, 10, 0, 0, -1, -1, 2 * 1024 + 10, np, nh);
        chk("abort_lcus", nh, 3);
        run_frame(2'd1, 0, 0, 0, -1, -1, 300, np, nh);
        chk("restart_pix", np, 300);
        chk("restart_lcus", nh, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
